// File: rtl/mmio_bridge_pkg.sv
// ============================================================================
// Module  : mmio_bridge_pkg
// Purpose : Shared constants and types for the MMIO bridge: IO address map,
//           IO page tag, active-low 7-segment codes and the IO register
//           selector with its address decoder.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_bridge_pkg;

  localparam logic [19:0] IO_PAGE    = 20'hFFFFF;

  localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN   = 32'hFFFF_F078;

  // {DP,G,F,E,D,C,B,A}, active-low, DP always dark
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  typedef enum logic [2:0] {
    REG_NONE  = 3'd0,
    REG_DIG   = 3'd1,
    REG_TIMER = 3'd2,
    REG_LED   = 3'd3,
    REG_SW    = 3'd4,
    REG_BTN   = 3'd5
  } io_reg_e;

  // Full-address match: misaligned or unlisted IO addresses select nothing.
  function automatic io_reg_e io_decode(input logic [31:0] a);
    case (a)
      ADDR_DIG:   return REG_DIG;
      ADDR_TIMER: return REG_TIMER;
      ADDR_LED:   return REG_LED;
      ADDR_SW:    return REG_SW;
      ADDR_BTN:   return REG_BTN;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_bridge_if.sv
// ============================================================================
// Module  : mmio_bridge_if
// Purpose : CPU data-memory port as seen by the bridge. Single-cycle, no
//           handshake: an access completes in the cycle it is presented.
// Ports   : addr  - byte address (CPU -> bridge)
//           wdata - store data   (CPU -> bridge)
//           we    - store enable (CPU -> bridge)
//           rdata - load data    (bridge -> CPU, combinational)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_bridge_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

`default_nettype wire

// File: rtl/mmio_bridge_seg7_decode.sv
// ============================================================================
// Module  : seg7_decode
// Purpose : Hex nibble to active-low 7-segment pattern, DP off.
// Ports   : nibble (in, 4) - hex digit
//           seg    (out, 8) - {DP,G,F,E,D,C,B,A}, active-low
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
  import mmio_bridge_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
// ============================================================================
// Module  : mmio_bridge
// Purpose : Data-memory-side address decoder for a single-cycle CPU. Routes
//           accesses to DRAM or to on-board peripheral registers (LED, SW,
//           BTN, 8-digit 7-seg display, free-running timer) and owns the
//           display scan sequencer, timer prescaler and input synchronisers.
// Ports   : cpu_clk, cpu_rst (async, active-low)
//           cpu        - CPU data port (mmio_bridge_if.slave)
//           dram_*     - DRAM word address / write enable / data
//           sw, btn    - raw board inputs
//           led        - LED drive, 1 = on
//           dig_en,seg - display digit enables and segments, active-low
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int TICK_DIV = 25000,
  parameter int DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  mmio_bridge_if.slave       cpu,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         seg
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic              w_io_hit;
  io_reg_e           w_sel;
  logic              w_wr_dig, w_wr_timer, w_wr_led;
  logic [3:0]        w_nibble;
  logic [7:0]        w_seg_raw;

  logic [31:0]       r_dig;
  logic [31:0]       r_timer;
  logic [23:0]       r_led;
  logic [TICK_W-1:0] r_presc;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [2:0]        r_idx;
  logic              r_disp_on;   // keeps the display dark until the first edge after reset
  logic [23:0]       r_sw_s1, r_sw_s2;
  logic [4:0]        r_btn_s1, r_btn_s2;

  assign w_io_hit   = (cpu.addr[31:12] == IO_PAGE);
  assign w_sel      = io_decode(cpu.addr);
  assign w_wr_dig   = cpu.we && (w_sel == REG_DIG);
  assign w_wr_timer = cpu.we && (w_sel == REG_TIMER);
  assign w_wr_led   = cpu.we && (w_sel == REG_LED);

  assign dram_addr  = cpu.addr[DRAM_AW+1:2];
  assign dram_we    = cpu.we && !w_io_hit;
  assign dram_wdata = cpu.wdata;

  // Zero-latency load path
  always_comb begin
    cpu.rdata = dram_rdata;
    if (w_io_hit) begin
      case (w_sel)
        REG_DIG:   cpu.rdata = r_dig;
        REG_TIMER: cpu.rdata = r_timer;
        REG_LED:   cpu.rdata = {8'h00, r_led};
        REG_SW:    cpu.rdata = {8'h00, r_sw_s2};
        REG_BTN:   cpu.rdata = {27'h0, r_btn_s2};
        default:   cpu.rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_dig      <= '0;
      r_timer    <= '0;
      r_led      <= '0;
      r_presc    <= '0;
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_disp_on  <= 1'b0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
    end else begin
      r_sw_s1   <= sw;
      r_sw_s2   <= r_sw_s1;
      r_btn_s1  <= btn;
      r_btn_s2  <= r_btn_s1;
      r_disp_on <= 1'b1;

      if (w_wr_dig) r_dig <= cpu.wdata;
      if (w_wr_led) r_led <= cpu.wdata[23:0];

      // CPU load takes priority over a coincident prescaler tick
      if (w_wr_timer) begin
        r_timer <= cpu.wdata;
        r_presc <= '0;
      end else if (r_presc == TICK_W'(TICK_DIV - 1)) begin
        r_presc <= '0;
        r_timer <= r_timer + 32'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  assign led      = r_led;
  assign w_nibble = r_dig[{r_idx, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .nibble (w_nibble),
    .seg    (w_seg_raw)
  );

  assign dig_en = r_disp_on ? ~(8'b1 << r_idx) : 8'hFF;
  assign seg    = r_disp_on ? w_seg_raw : 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
// ============================================================================
// Module  : tb_mmio_bridge
// Purpose : Self-checking bench for mmio_bridge with a behavioural model of
//           the address map, timer, display scan and input synchronisers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_bridge;

  localparam int SCAN_DIV = 4;
  localparam int TICK_DIV = 3;
  localparam int DRAM_AW  = 14;

  localparam logic [31:0] A_DIG   = 32'hFFFF_F000;
  localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] A_LED   = 32'hFFFF_F060;
  localparam logic [31:0] A_SW    = 32'hFFFF_F070;
  localparam logic [31:0] A_BTN   = 32'hFFFF_F078;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [DRAM_AW-1:0] dram_addr;
  logic               dram_we;
  logic [31:0]        dram_wdata;
  logic [31:0]        dram_rdata;
  logic [23:0]        sw;
  logic [4:0]         btn;
  logic [23:0]        led;
  logic [7:0]         dig_en;
  logic [7:0]         seg;

  mmio_bridge_if bus ();

  mmio_bridge #(.SCAN_DIV(SCAN_DIV), .TICK_DIV(TICK_DIV), .DRAM_AW(DRAM_AW)) dut (
    .cpu_clk    (clk),
    .cpu_rst    (rst_n),
    .cpu        (bus.slave),
    .dram_addr  (dram_addr),
    .dram_we    (dram_we),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw         (sw),
    .btn        (btn),
    .led        (led),
    .dig_en     (dig_en),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  // DRAM stand-in
  logic [31:0] dram_mem [0:(1<<DRAM_AW)-1];
  always @(posedge clk) if (dram_we) dram_mem[dram_addr] <= dram_wdata;
  assign dram_rdata = dram_mem[dram_addr];

  // ---------------- reference model ----------------
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_dig;
  logic [23:0] m_led;
  logic [31:0] m_tw;          // value last loaded into TIMER
  int unsigned m_tk;          // edge number of that load
  int unsigned m_n;           // edges since reset release
  logic [23:0] q_sw [$];
  logic [4:0]  q_btn [$];

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [31:0] m_timer();
    return m_tw + 32'((m_n - m_tk) / TICK_DIV);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    int unsigned key;
    key = int'(a[DRAM_AW+1:2]);
    if (a[31:12] != 20'hFFFFF) return m_mem.exists(key) ? m_mem[key] : 32'h0;
    case (a)
      A_DIG:   return m_dig;
      A_TIMER: return m_timer();
      A_LED:   return {8'h00, m_led};
      A_SW:    return {8'h00, q_sw[0]};
      A_BTN:   return {27'h0, q_btn[0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_dig = '0; m_led = '0; m_tw = '0; m_tk = 0; m_n = 0;
    q_sw = '{24'h0, 24'h0};
    q_btn = '{5'h0, 5'h0};
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One CPU cycle: drive at negedge, check combinational view, clock, update model.
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic w,
                     input logic [23:0] s, input logic [4:0] b);
    logic [2:0]  idx;
    logic [7:0]  exp_en, exp_seg;
    logic [31:0] exp_rd;
    bit          io;
    bus.addr = a; bus.wdata = wd; bus.we = w; sw = s; btn = b;
    #1;
    io     = (a[31:12] == 20'hFFFFF);
    exp_rd = m_rdata(a);
    idx    = 3'((m_n / SCAN_DIV) % 8);
    exp_en  = (m_n > 0) ? ~(8'b1 << idx) : 8'hFF;
    exp_seg = (m_n > 0) ? seg_of(m_dig[idx*4 +: 4]) : 8'hFF;
    check_val("rdata", bus.rdata, exp_rd);
    check_val("dram_we", {31'h0, dram_we}, {31'h0, (w && !io)});
    check_val("dram_addr", {18'h0, dram_addr}, {18'h0, a[DRAM_AW+1:2]});
    check_val("dram_wdata", dram_wdata, wd);
    check_val("led", {8'h0, led}, {8'h0, m_led});
    check_val("dig_en", {24'h0, dig_en}, {24'h0, exp_en});
    check_val("seg", {24'h0, seg}, {24'h0, exp_seg});
    @(posedge clk);
    if (rst_n) begin
      if (w && !io) m_mem[int'(a[DRAM_AW+1:2])] = wd;
      if (w && a == A_DIG) m_dig = wd;
      if (w && a == A_LED) m_led = wd[23:0];
      if (w && a == A_TIMER) begin m_tw = wd; m_tk = m_n + 1; end
      m_n++;
      q_sw.push_back(s);  void'(q_sw.pop_front());
      q_btn.push_back(b); void'(q_btn.pop_front());
    end
    @(negedge clk);
  endtask

  logic [23:0] cur_sw;
  logic [4:0]  cur_btn;

  task automatic idle(input logic [31:0] a, input int cnt);
    for (int i = 0; i < cnt; i++) cyc(a, 32'h0, 1'b0, cur_sw, cur_btn);
  endtask

  task automatic rand_cycle();
    logic [31:0] a, wd;
    logic        w;
    int          k;
    wd = $urandom;
    w  = $urandom_range(0, 1) == 1;
    k  = $urandom_range(0, 9);
    case (k)
      0: a = A_DIG;
      1: a = A_TIMER;
      2: a = A_LED;
      3: a = A_SW;
      4: a = A_BTN;
      5: a = {20'hFFFFF, 12'($urandom_range(0, 4095))};
      default: begin
        a = {16'h0000, 14'($urandom), 2'b00};
      end
    endcase
    if ($urandom_range(0, 5) == 0) cur_sw = 24'($urandom);
    if ($urandom_range(0, 5) == 0) cur_btn = 5'($urandom);
    cyc(a, wd, w, cur_sw, cur_btn);
  endtask

  initial begin
    for (int i = 0; i < (1 << DRAM_AW); i++) dram_mem[i] = 32'h0;
    cur_sw = '0; cur_btn = '0;
    bus.addr = A_TIMER; bus.wdata = '0; bus.we = 1'b0; sw = '0; btn = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);

    // reset held low for 3 cycles, display dark, registers zero
    idle(A_TIMER, 3);
    rst_n = 1'b1;
    idle(A_TIMER, 1);
    idle(A_LED, 2);

    // DRAM store then load
    cyc(32'h0000_0010, 32'h1234_5678, 1'b1, cur_sw, cur_btn);
    cyc(32'h0000_0010, 32'h0, 1'b0, cur_sw, cur_btn);

    // LED store then load
    cyc(A_LED, 32'h00AB_CDEF, 1'b1, cur_sw, cur_btn);
    cyc(A_LED, 32'h0, 1'b0, cur_sw, cur_btn);

    // display scan over a full rotation and more
    cyc(A_DIG, 32'h8765_4321, 1'b1, cur_sw, cur_btn);
    idle(A_DIG, 40);

    // TIMER load coinciding with a prescaler tick, then wrap to 0
    for (int i = 0; i < TICK_DIV; i++)
      if (((m_n + 1 - m_tk) % TICK_DIV) != 0) idle(A_TIMER, 1);
    cyc(A_TIMER, 32'hFFFF_FFFF, 1'b1, cur_sw, cur_btn);
    idle(A_TIMER, 5);

    // switch change seen through the synchroniser
    cur_sw = 24'h00_0F0F;
    idle(A_SW, 4);
    cur_btn = 5'h15;
    idle(A_BTN, 4);
    idle(32'hFFFF_F100, 2);

    for (int i = 0; i < 600; i++) rand_cycle();

    // asynchronous reset mid-cycle: display goes dark before any edge
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_dig_en", {24'h0, dig_en}, 32'hFF);
    check_val("async_seg", {24'h0, seg}, 32'hFF);
    check_val("async_led", {8'h0, led}, 32'h0);
    model_reset();
    @(negedge clk);
    cur_sw = '0; cur_btn = '0;
    idle(A_DIG, 2);
    rst_n = 1'b1;
    idle(A_TIMER, 4);
    for (int i = 0; i < 100; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
